// File: rtl/sram_controller.sv
// sram_controller
//
// Turns single-cycle load/store requests from the MEM stage into multi-cycle
// accesses on an asynchronous-style SRAM (word addressed, 32-bit shared data
// bus). The access is held for WAIT_CYCLES core cycles so that an SRAM clocked
// at half the core rate sees at least two of its own edges.
//
// Ports
//   clk         core clock, all state changes on the rising edge
//   reset       synchronous, active-low
//   wr_en       store request (wins if rd_en is also high)
//   rd_en       load request
//   address     byte address from the ALU
//   write_data  store data
//   read_data   load data, updated only by a completed read
//   ready       low while a request is pending, high in the completion cycle
//   addr_err    high in the completion cycle of an out-of-range access
//   SRAM_WE_N   SRAM write enable, active-low
//   SRAM_ADDR   SRAM word address
//   SRAM_DQ     SRAM data bus, driven only during a write access
//   dbg_state   current FSM state (0 = IDLE, 1 = ACCESS, 2 = DONE)
//
// Handshake: a request (wr_en | rd_en) seen in IDLE is accepted on that rising
// edge. The requester must hold it stable while ready is low; ready high marks
// the single cycle in which the access completes (and read_data is valid for a
// read). The request is not re-accepted in that cycle because the pipeline
// advances on it.

module sram_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 5,
    parameter int          ADDR_W      = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic              addr_err,
    output logic              SRAM_WE_N,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [31:0]       SRAM_DQ,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;

    logic [ADDR_W-1:0] word_q;
    logic [31:0]       data_q;
    logic              write_q;
    logic              err_q;

    logic [31:0]       offset;
    logic [31:0]       off_word;
    logic              out_of_range;
    logic              req;
    logic              last;
    logic              drive;

    assign req      = wr_en | rd_en;
    assign offset   = address - BASE_ADDR;
    assign off_word = offset >> 2;

    // The subtraction wraps for addresses below the base, so that case is
    // caught explicitly rather than by the size test.
    assign out_of_range = (address < BASE_ADDR)
                       || (address[1:0] != 2'b00)
                       || ({32'd0, off_word} >= (64'd1 << ADDR_W));

    assign last = (cnt == 4'(WAIT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    state_nxt = out_of_range ? DONE : ACCESS;
                    cnt_nxt   = 4'd0;
                end
            end
            ACCESS: begin
                cnt_nxt = cnt + 4'd1;
                if (last) begin
                    state_nxt = DONE;
                    cnt_nxt   = 4'd0;
                end
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            word_q    <= '0;
            data_q    <= 32'd0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            read_data <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req) begin
                write_q <= wr_en;
                err_q   <= out_of_range;
                data_q  <= write_data;
                // An out-of-range access leaves the SRAM pins untouched; a
                // failed read must show zero already in its DONE cycle.
                if (!out_of_range) begin
                    word_q <= off_word[ADDR_W-1:0];
                end else if (!wr_en) begin
                    read_data <= 32'd0;
                end
            end
            if (state == ACCESS && last && !write_q) begin
                read_data <= SRAM_DQ;
            end
        end
    end

    // The bus is only ever driven during a write access, so the SRAM may
    // drive it freely in every other cycle.
    assign drive     = (state == ACCESS) && write_q;
    assign SRAM_WE_N = ~drive;
    assign SRAM_DQ   = drive ? data_q : 32'hzzzz_zzzz;
    assign SRAM_ADDR = word_q;
    assign addr_err  = (state == DONE) && err_q;
    assign dbg_state = state;

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sits inside the ARM core between the MEM stage and the external SRAM pins.
- Converts single-cycle load/store requests into multi-cycle SRAM accesses on a 17-bit word-address, 32-bit bidirectional bus.
- Drives a ready signal; the hazard/freeze logic uses ~ready to stall the pipeline.
- Sized for an SRAM clocked at half the core clock. The access is held long enough to cover at least two SRAM clock edges.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- WAIT_CYCLES, 5: core cycles the ACCESS state is held. Legal range 2..15.
- ADDR_W, 17: SRAM word-address width.

Ports:
- clk  in  1  core clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- wr_en  in  1  store request from MEM stage.
- rd_en  in  1  load request from MEM stage.
- address  in  32  byte address from ALU result.
- write_data  in  32  store data (Rm value).
- read_data  out  32  load data returned to WB.
- ready  out  1  high when no request is pending or the access completes this cycle.
- addr_err  out  1  pulses with ready when the access was out of range.
- SRAM_WE_N  out  1  SRAM write enable, active-low.
- SRAM_ADDR  out  ADDR_W  SRAM word address.
- SRAM_DQ  inout  32  SRAM data bus.

Behaviour:
- States: IDLE, ACCESS, DONE. Counter cnt is 4 bits.
- Reset (reset==0 at a rising edge), applied identically from any state including mid-access:
  - state=IDLE, cnt=0
  - SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ released (high-Z)
  - read_data=0, addr_err=0
  - internal latched address/data/op cleared
- Address mapping: word = (address - BASE_ADDR) >> 2, truncated to ADDR_W bits.
- Range check:
  - Out of range if address < BASE_ADDR, address[1:0] != 0, or (address - BASE_ADDR) >> 2 >= 2^ADDR_W.
- IDLE:
  - ready = ~(rd_en | wr_en), combinational.
  - On a request, latch word, write_data and op, then go to ACCESS with cnt=0.
  - If wr_en and rd_en are both high, the access is a write.
  - If out of range, go directly to DONE with the error flag latched. No SRAM activity.
- ACCESS:
  - ready=0.
  - SRAM_ADDR holds the latched word.
  - Write: SRAM_WE_N=0 and SRAM_DQ driven with the latched data for all WAIT_CYCLES cycles.
  - Read: SRAM_WE_N=1 and SRAM_DQ high-Z.
  - cnt increments each cycle. When cnt==WAIT_CYCLES-1: go to DONE, and on a read register SRAM_DQ into read_data.
- DONE:
  - ready=1; SRAM_WE_N=1; SRAM_DQ high-Z.
  - addr_err=1 if the error flag is latched.
  - An out-of-range read sets read_data=0.
  - Next state is unconditionally IDLE. The pipeline advances on this cycle, so the still-asserted request is not re-accepted.
- Latency for a request first seen in cycle C:
  - ready is low in cycles C..C+WAIT_CYCLES.
  - ready is high in C+WAIT_CYCLES+1, with read_data valid in that cycle.
  - Out-of-range access: ready is low in C and high in C+1.
- read_data holds its value until the next completed read.
- Writes do not change read_data.
- SRAM_DQ is driven only in ACCESS during a write; there is never contention in any other state.
- Request inputs are ignored outside IDLE; they must be held stable by the freeze.

Test Plan:
- Reset low for 2 cycles during a write ACCESS -> next cycle SRAM_WE_N=1, SRAM_DQ=Z, state IDLE, ready=1 with no request, read_data=0.
- Write address=0x408, write_data=0xDEADBEEF, WAIT_CYCLES=5 ->
  - SRAM_ADDR=2 and SRAM_WE_N=0 for exactly 5 cycles, SRAM_DQ=0xDEADBEEF.
  - ready low 6 cycles, then high 1 cycle; addr_err=0.
- Read back address=0x408 with SRAM model ->
  - SRAM_WE_N stays 1, SRAM_DQ undriven by controller.
  - read_data=0xDEADBEEF in the ready-high cycle.
- Back-to-back: write 0x400 = 0x11111111, then read 0x400 on the next accepted request -> second access starts in the cycle after DONE; read returns 0x11111111.
- Out of range: read address=0x3FC, then write address=0x402 -> each gives ready low 1 cycle, then ready=1 and addr_err=1; SRAM_WE_N never 0; read gives read_data=0.
- wr_en=rd_en=1 at address 0x40C, data 0xA5A5A5A5 -> performed as write (SRAM_WE_N=0, SRAM_ADDR=3); a later read of 0x40C returns 0xA5A5A5A5.
